// File: rtl/sw_debounce.sv
// Switch input conditioner: two-flop synchroniser, per-bit stability filter,
// and registered one-cycle rise/fall strobes for each of the WIDTH switches.
module sw_debounce #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] sw_q, sw_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] commit;

    // Each bit has its own counter; state is derived from s2 vs the accepted level.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             commit_bit;
        state_e           state;

        always_comb begin
            state      = (s2_q[gi] != sw_q[gi]) ? ST_PENDING : ST_STABLE;
            cnt_d      = '0;
            commit_bit = 1'b0;
            case (state)
                ST_STABLE: begin
                    cnt_d = '0;
                end
                ST_PENDING: begin
                    if (cnt_q == CNT_MAX) begin
                        commit_bit = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: cnt_d = '0;
            endcase
        end

        assign commit[gi] = commit_bit;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // A commit always moves the output to s2, so strobe polarity follows s2.
    always_comb begin
        sw_d      = (sw_q & ~commit) | (s2_q & commit);
        rise_d    = commit & s2_q;
        fall_d    = commit & ~s2_q;
        changed_d = |commit;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            sw_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= sw_raw;
            s2_q      <= s1_q;
            sw_q      <= sw_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign sw_o    = sw_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
    assign changed = changed_q;

endmodule
